// File: rtl/gb_sprite_pkg.sv
// Shared types for the sprite fetch path: fetch FSM states, object FIFO entry
// and the per-pixel merge priority rule.
package gb_sprite_pkg;

  localparam int unsigned OBJ_FIFO_DEPTH = 8;
  localparam int unsigned COLOR_W        = 2;
  localparam int unsigned PAL_W          = 3;
  localparam int unsigned SLOT_W         = 4;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_C1,
    ST_LO0,
    ST_LO1,
    ST_HI0,
    ST_HI1,
    ST_DONE
  } fetch_state_t;

  typedef struct packed {
    logic [COLOR_W-1:0] color;
    logic [PAL_W-1:0]   pal;
    logic               prio;
    logic [SLOT_W-1:0]  slot;
  } obj_entry_t;

  // Transparent pixels never win; DMG keeps the first opaque pixel, GBC lets a
  // lower evaluator slot (lower OAM index) take over an opaque one.
  function automatic logic obj_wins(input logic gbc, input obj_entry_t cand,
                                    input obj_entry_t old);
    if (cand.color == 2'd0) return 1'b0;
    if (old.color == 2'd0) return 1'b1;
    return gbc && (cand.slot < old.slot);
  endfunction

endpackage

// File: rtl/obj_pixel_fifo.sv
// Eight-entry object pixel FIFO: shifts toward the head on mixer consumption
// and merges a freshly fetched sprite row into the (already shifted) contents.
module obj_pixel_fifo
  import gb_sprite_pkg::*;
(
  input  logic                                clk,
  input  logic                                clear,
  input  logic                                shift,
  input  logic                                merge,
  input  logic                                isGBC,
  input  logic [OBJ_FIFO_DEPTH-1:0][COLOR_W-1:0] row,
  input  logic [PAL_W-1:0]                    pal,
  input  logic                                prio,
  input  logic [SLOT_W-1:0]                   slot,
  output obj_entry_t                          head
);

  obj_entry_t [OBJ_FIFO_DEPTH-1:0] fifo_q;
  obj_entry_t [OBJ_FIFO_DEPTH-1:0] shifted;
  obj_entry_t [OBJ_FIFO_DEPTH-1:0] fifo_d;
  obj_entry_t                      cand;

  // Shift first, then merge into the shifted image.
  always_comb begin
    shifted = fifo_q;
    cand    = '0;
    if (shift) begin
      for (int unsigned i = 0; i < OBJ_FIFO_DEPTH - 1; i++) begin
        shifted[i] = fifo_q[i + 1];
      end
      shifted[OBJ_FIFO_DEPTH-1] = '0;
    end
    fifo_d = shifted;
    for (int unsigned i = 0; i < OBJ_FIFO_DEPTH; i++) begin
      cand.color = row[i];
      cand.pal   = pal;
      cand.prio  = prio;
      cand.slot  = slot;
      if (merge && obj_wins(isGBC, cand, shifted[i])) begin
        fifo_d[i] = cand;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (clear) begin
      fifo_q <= '0;
    end else begin
      fifo_q <= fifo_d;
    end
  end

  assign head = fifo_q[0];

endmodule

// File: rtl/sprite_fetcher.sv
// Sequences one sprite tile-row fetch (attribute latch, low/high bitplane VRAM
// reads) and merges the decoded row into the object pixel FIFO.
module sprite_fetcher
  import gb_sprite_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        ce,
  input  logic        isGBC,
  input  logic        lcd_on,
  input  logic        line_start,
  input  logic        sprite_fetch,
  input  logic [10:0] sprite_addr,
  input  logic [7:0]  sprite_attr,
  input  logic [3:0]  sprite_index,
  output logic        sprite_fetch_c1,
  output logic        sprite_fetch_done,
  input  logic        bg_fetch_ready,
  output logic [12:0] vram_addr,
  output logic        vram_bank,
  output logic        vram_rd,
  input  logic [7:0]  vram_data,
  output logic        busy,
  input  logic        pix_shift,
  output logic [1:0]  obj_color,
  output logic [2:0]  obj_pal,
  output logic        obj_prio
);

  fetch_state_t state;
  logic [7:0]   lo_q;
  logic [7:0]   hi_q;
  logic         abort;
  logic         merge;
  logic [OBJ_FIFO_DEPTH-1:0][COLOR_W-1:0] row;
  logic [PAL_W-1:0] pal_new;
  obj_entry_t   head;
  logic [SLOT_W-1:0] unused_head_slot;
  logic         unused_attr_yflip;

  assign abort = reset | ~lcd_on | (ce & line_start);
  assign merge = ce & ~abort & (state == ST_DONE);

  always_ff @(posedge clk) begin
    if (abort) begin
      state             <= ST_IDLE;
      sprite_fetch_c1   <= 1'b0;
      sprite_fetch_done <= 1'b0;
      vram_addr         <= '0;
      vram_bank         <= 1'b0;
      vram_rd           <= 1'b0;
      busy              <= 1'b0;
      lo_q              <= '0;
      hi_q              <= '0;
    end else if (ce) begin
      sprite_fetch_c1   <= 1'b0;
      sprite_fetch_done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (sprite_fetch && bg_fetch_ready) begin
            state           <= ST_C1;
            sprite_fetch_c1 <= 1'b1;
            busy            <= 1'b1;
          end
        end
        ST_C1: begin
          state     <= ST_LO0;
          vram_rd   <= 1'b1;
          vram_addr <= {1'b0, sprite_addr, 1'b0};
          vram_bank <= isGBC & sprite_attr[3];
        end
        ST_LO0: state <= ST_LO1;
        ST_LO1: begin
          state     <= ST_HI0;
          lo_q      <= vram_data;
          vram_addr <= {1'b0, sprite_addr, 1'b1};
        end
        ST_HI0: state <= ST_HI1;
        ST_HI1: begin
          state             <= ST_DONE;
          hi_q              <= vram_data;
          vram_rd           <= 1'b0;
          vram_addr         <= '0;
          vram_bank         <= 1'b0;
          sprite_fetch_done <= 1'b1;
        end
        ST_DONE: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Pixel 0 is the leftmost; X-flip reverses the bit order.
  always_comb begin
    row = '0;
    for (int unsigned i = 0; i < OBJ_FIFO_DEPTH; i++) begin
      if (sprite_attr[5]) begin
        row[i] = {hi_q[3'(i)], lo_q[3'(i)]};
      end else begin
        row[i] = {hi_q[3'(OBJ_FIFO_DEPTH - 1 - i)], lo_q[3'(OBJ_FIFO_DEPTH - 1 - i)]};
      end
    end
  end

  assign pal_new = isGBC ? sprite_attr[2:0] : {2'b00, sprite_attr[4]};

  obj_pixel_fifo u_fifo (
    .clk   (clk),
    .clear (abort),
    .shift (ce & pix_shift),
    .merge (merge),
    .isGBC (isGBC),
    .row   (row),
    .pal   (pal_new),
    .prio  (sprite_attr[7]),
    .slot  (sprite_index),
    .head  (head)
  );

  assign obj_color         = head.color;
  assign obj_pal           = head.pal;
  assign obj_prio          = head.prio;
  assign unused_head_slot  = head.slot;
  assign unused_attr_yflip = sprite_attr[6];

endmodule

// File: tb/tb_sprite_fetcher.sv
// Scoreboard bench for sprite_fetcher: stimulus queues expected VRAM reads,
// strobe timings and FIFO pixels; a negedge monitor pops and compares them.
module tb_sprite_fetcher;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        ce = 1'b0;
  logic        isGBC = 1'b0;
  logic        lcd_on = 1'b1;
  logic        line_start = 1'b0;
  logic        sprite_fetch = 1'b0;
  logic [10:0] sprite_addr = '0;
  logic [7:0]  sprite_attr = '0;
  logic [3:0]  sprite_index = '0;
  logic        sprite_fetch_c1;
  logic        sprite_fetch_done;
  logic        bg_fetch_ready = 1'b0;
  logic [12:0] vram_addr;
  logic        vram_bank;
  logic        vram_rd;
  logic [7:0]  vram_data = '0;
  logic        busy;
  logic        pix_shift = 1'b0;
  logic [1:0]  obj_color;
  logic [2:0]  obj_pal;
  logic        obj_prio;

  sprite_fetcher dut (
    .clk(clk), .reset(reset), .ce(ce), .isGBC(isGBC), .lcd_on(lcd_on),
    .line_start(line_start), .sprite_fetch(sprite_fetch), .sprite_addr(sprite_addr),
    .sprite_attr(sprite_attr), .sprite_index(sprite_index),
    .sprite_fetch_c1(sprite_fetch_c1), .sprite_fetch_done(sprite_fetch_done),
    .bg_fetch_ready(bg_fetch_ready), .vram_addr(vram_addr), .vram_bank(vram_bank),
    .vram_rd(vram_rd), .vram_data(vram_data), .busy(busy), .pix_shift(pix_shift),
    .obj_color(obj_color), .obj_pal(obj_pal), .obj_prio(obj_prio)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [1:0] color;
    logic [2:0] pal;
    logic       prio;
    logic [3:0] slot;
  } ment_t;

  ment_t       model [8];
  logic [7:0]  mem [8192];
  logic [12:0] addr_lat = '0;
  bit          ce_rand = 1'b0;
  int          ce_cnt = 0;
  int          checks = 0;
  int          errors = 0;
  logic [13:0] exp_addr [$];
  int          exp_c1 [$];
  int          exp_done [$];
  logic [5:0]  exp_pix [$];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, got, exp);
    end
  endtask

  task automatic unexpected(input string name);
    checks++;
    errors++;
    $display("FAIL %s: got an event, expected none", name);
  endtask

  // VRAM: data for the address seen in one ce appears in the next ce.
  always @(posedge clk) begin
    #1;
    if (ce) vram_data = mem[addr_lat];
    #1;
    ce = ce_rand ? ($urandom_range(3) != 0) : 1'b1;
  end

  // Monitor: one sample per ce, away from the clock edge.
  always @(negedge clk) begin
    if (ce) begin
      addr_lat = vram_addr;
      if (vram_rd) begin
        if (exp_addr.size() == 0) unexpected("vram_rd");
        else check("vram_bank_addr", 32'({vram_bank, vram_addr}), 32'(exp_addr.pop_front()));
      end
      if (sprite_fetch_c1) begin
        if (exp_c1.size() == 0) unexpected("sprite_fetch_c1");
        else check("c1_ce_index", 32'(ce_cnt), 32'(exp_c1.pop_front()));
      end
      if (sprite_fetch_done) begin
        if (exp_done.size() == 0) unexpected("sprite_fetch_done");
        else check("done_ce_index", 32'(ce_cnt), 32'(exp_done.pop_front()));
      end
      if (pix_shift) begin
        if (exp_pix.size() == 0) unexpected("pix_shift");
        else check("obj_pixel", 32'({obj_color, obj_pal, obj_prio}), 32'(exp_pix.pop_front()));
      end
      ce_cnt++;
    end
  end

  task automatic tick();
    do @(posedge clk); while (!ce);
    #1;
  endtask

  function automatic void model_clear();
    for (int i = 0; i < 8; i++) model[i] = '0;
  endfunction

  function automatic void model_shift();
    for (int i = 0; i < 7; i++) model[i] = model[i + 1];
    model[7] = '0;
  endfunction

  // Reference merge straight from the pixel/priority rules.
  function automatic void model_merge(input logic [7:0] lo, input logic [7:0] hi,
                                      input logic [7:0] attr, input logic [3:0] slot,
                                      input logic gbc);
    for (int i = 0; i < 8; i++) begin
      int b;
      logic [1:0] c;
      bit take;
      b = attr[5] ? i : 7 - i;
      c = {hi[b], lo[b]};
      if (c == 2'd0) take = 0;
      else if (model[i].color == 2'd0) take = 1;
      else take = gbc && (slot < model[i].slot);
      if (take) begin
        model[i].color = c;
        model[i].pal   = gbc ? attr[2:0] : {2'b00, attr[4]};
        model[i].prio  = attr[7];
        model[i].slot  = slot;
      end
    end
  endfunction

  task automatic issue(input logic [10:0] a, input logic [7:0] lo, input logic [7:0] hi,
                       input logic [7:0] attr, input logic [3:0] slot, input int nrd,
                       output int n);
    logic [12:0] base;
    base = {1'b0, a, 1'b0};
    mem[base] = lo;
    mem[base | 13'd1] = hi;
    sprite_addr = a;
    sprite_attr = attr;
    sprite_index = slot;
    sprite_fetch = 1'b1;
    bg_fetch_ready = 1'b1;
    n = ce_cnt;
    exp_c1.push_back(n + 1);
    for (int k = 0; k < nrd; k++) exp_addr.push_back({isGBC & attr[3], base | 13'(k / 2)});
  endtask

  task automatic do_fetch(input logic [10:0] a, input logic [7:0] lo, input logic [7:0] hi,
                          input logic [7:0] attr, input logic [3:0] slot);
    int n;
    issue(a, lo, hi, attr, slot, 4, n);
    exp_done.push_back(n + 6);
    tick();
    check("busy_in_c1", 32'(busy), 32'd1);
    sprite_fetch = 1'($urandom_range(1));
    bg_fetch_ready = 1'($urandom_range(1));
    repeat (6) tick();
    model_merge(lo, hi, attr, slot, isGBC);
    check("busy_back_in_idle", 32'(busy), 32'd0);
    sprite_fetch = 1'b1;
    bg_fetch_ready = 1'b1;
  endtask

  task automatic idle();
    sprite_fetch = 1'b0;
    tick();
  endtask

  task automatic drain(input int k);
    for (int j = 0; j < k; j++) begin
      pix_shift = 1'b1;
      exp_pix.push_back({model[0].color, model[0].pal, model[0].prio});
      model_shift();
      tick();
    end
    pix_shift = 1'b0;
  endtask

  // Abort a fetch with line_start while in HI0; nothing may be merged.
  task automatic abort_hi0();
    int n;
    issue(11'h2A5, 8'hFF, 8'hFF, 8'h10, 4'd3, 3, n);
    repeat (4) tick();
    sprite_fetch = 1'b0;
    line_start = 1'b1;
    tick();
    line_start = 1'b0;
    model_clear();
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_vram_rd", 32'(vram_rd), 32'd0);
    check("abort_done", 32'(sprite_fetch_done), 32'd0);
    check("abort_head_color", 32'(obj_color), 32'd0);
    repeat (8) tick();
    drain(8);
  endtask

  logic [10:0] r_a;
  logic [7:0]  r_lo, r_hi, r_attr;
  logic [3:0]  r_slot;
  int          r_sel;

  initial begin
    model_clear();
    for (int i = 0; i < 8192; i++) mem[i] = '0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    check("rst_c1", 32'(sprite_fetch_c1), 32'd0);
    check("rst_done", 32'(sprite_fetch_done), 32'd0);
    check("rst_vram", 32'({vram_addr, vram_bank, vram_rd}), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_obj", 32'({obj_color, obj_pal, obj_prio}), 32'd0);
    ce_rand = 1'b1;
    tick();

    // Basic DMG row, then the same row X-flipped.
    isGBC = 1'b0;
    do_fetch(11'h123, 8'hF0, 8'hCC, 8'h10, 4'd0); idle(); drain(8);
    do_fetch(11'h123, 8'hF0, 8'hCC, 8'h30, 4'd0); idle(); drain(8);

    // DMG overlap: existing opaque pixels are kept.
    do_fetch(11'h010, 8'hAA, 8'h00, 8'h00, 4'd4); idle();
    do_fetch(11'h011, 8'hFF, 8'hFF, 8'h10, 4'd1); idle(); drain(8);

    // GBC priority: lower slot replaces, higher slot does not.
    isGBC = 1'b1;
    do_fetch(11'h200, 8'h00, 8'hFF, 8'h03, 4'd5); idle();
    do_fetch(11'h201, 8'hFF, 8'h00, 8'h0C, 4'd2); idle(); drain(8);
    do_fetch(11'h200, 8'h00, 8'hFF, 8'h03, 4'd5); idle();
    do_fetch(11'h202, 8'hFF, 8'h00, 8'h8E, 4'd7); idle(); drain(8);

    // Back-to-back with sprite_fetch held high.
    isGBC = 1'b0;
    do_fetch(11'h300, 8'h0F, 8'h33, 8'h80, 4'd0);
    do_fetch(11'h301, 8'hC3, 8'h5A, 8'h28, 4'd1);
    idle(); drain(8);

    // No start while the background fetcher is busy.
    sprite_fetch = 1'b1;
    bg_fetch_ready = 1'b0;
    repeat (5) tick();
    do_fetch(11'h055, 8'h3C, 8'h81, 8'h00, 4'd1); idle(); drain(8);

    // Preload the FIFO, then abort a fetch mid-way.
    do_fetch(11'h077, 8'hFF, 8'h0F, 8'h10, 4'd0); idle();
    abort_hi0();

    // Randomized fetches, partial drains and clears.
    for (int it = 0; it < 40; it++) begin
      isGBC = 1'($urandom_range(1));
      r_a = 11'($urandom); r_lo = 8'($urandom); r_hi = 8'($urandom);
      r_attr = 8'($urandom); r_slot = 4'($urandom_range(9));
      do_fetch(r_a, r_lo, r_hi, r_attr, r_slot);
      if ($urandom_range(2) == 0) begin
        r_a = 11'($urandom); r_lo = 8'($urandom); r_hi = 8'($urandom);
        r_attr = 8'($urandom); r_slot = 4'($urandom_range(9));
        do_fetch(r_a, r_lo, r_hi, r_attr, r_slot);
      end
      idle();
      drain($urandom_range(8));
      r_sel = $urandom_range(9);
      if (r_sel == 0) begin
        line_start = 1'b1; tick(); line_start = 1'b0; model_clear();
      end else if (r_sel == 1) begin
        lcd_on = 1'b0; tick(); lcd_on = 1'b1; model_clear();
      end
    end
    drain(8);

    repeat (4) tick();
    check("addr_queue_empty", 32'(exp_addr.size()), 32'd0);
    check("c1_queue_empty", 32'(exp_c1.size()), 32'd0);
    check("done_queue_empty", 32'(exp_done.size()), 32'd0);
    check("pix_queue_empty", 32'(exp_pix.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout, expected end of test");
    $fatal(1, "watchdog expired");
  end

endmodule
